// File: rtl/ieeedrv_host_hs.sv
// ieeedrv_host_hs -- controller-side IEEE-488 three-wire handshake engine.
//
// This is the PET end of the bus. As talker it sends one byte at a time,
// either as a command (ATN low) or as data (optionally with EOI), using
// DAV/NRFD/NDAC. When nothing is queued to send and rx_en is high, it acts
// as listener and accepts one byte from the talking drive.
//
// All bus signals are active low. bus_o is this block's contribution to the
// wired-AND bus (1 = released). bus_i is the resolved bus. All handshake
// moves happen only on ce ticks. bus_o is decoded from registered state
// only, so there is no combinational path from bus_i to bus_o.
//
// Ports
//   clk_sys   system clock
//   reset     synchronous active-high reset
//   ce        handshake tick enable
//   tx_valid  byte to send is pending
//   tx_ready  high in IDLE; byte taken when tx_valid & tx_ready & ce
//   tx_data   byte to send, positive logic
//   tx_atn    send the byte as a command
//   tx_eoi    assert EOI with this byte (ignored for commands)
//   atn_hold  keep ATN asserted while idle, between command bytes
//   tx_done   one-clock pulse when a send finishes
//   tx_err    valid with tx_done: 1 = timeout or no listener
//   rx_en     act as listener when no send is pending
//   rx_valid  one-clock pulse: rx_data/rx_eoi hold a new byte
//   rx_data   received byte, positive logic
//   rx_eoi    EOI was low while DAV was low
//   bus_i     resolved bus
//   bus_o     our bus drive

package ieeedrv_host_hs_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic       atn;
    logic       dav;
    logic       nrfd;
    logic       ndac;
    logic       eoi;
    logic       srq;
    logic       ren;
    logic       ifc;
  } st_ieee_bus;
endpackage

module ieeedrv_host_hs
  import ieeedrv_host_hs_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int SETTLE  = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       atn_hold,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       rx_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_eoi,
  input  st_ieee_bus bus_i,
  output st_ieee_bus bus_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    T_WAIT_RFD,
    T_SETTLE,
    T_WAIT_DAC,
    T_RELEASE,
    L_READY,
    L_ACCEPT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       data_latch;
  logic             atn_latch;
  logic             eoi_latch;
  logic             talking;

  // The talker never looks at these bus lines.
  logic unused_bus;
  assign unused_bus = ^{bus_i.atn, bus_i.eoi, bus_i.srq, bus_i.ren, bus_i.ifc};

  // Tick counter: stops at TIMEOUT rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_W'(TIMEOUT))
      return v;
    return v + 1'b1;
  endfunction

  assign talking  = (state == T_WAIT_RFD) || (state == T_SETTLE) || (state == T_WAIT_DAC);
  assign tx_ready = (state == IDLE);

  // Outgoing byte: datapath latch, loaded only when a byte is accepted.
  always_ff @(posedge clk_sys) begin
    if (ce && state == IDLE && tx_valid)
      data_latch <= tx_data;
  end

  // Handshake FSM
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      atn_latch <= 1'b0;
      eoi_latch <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_eoi    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
      rx_valid <= 1'b0;
      if (ce) begin
        case (state)
          IDLE: begin
            if (tx_valid) begin
              atn_latch <= tx_atn;
              eoi_latch <= tx_eoi & ~tx_atn;
              cnt       <= '0;
              state     <= T_WAIT_RFD;
            end else if (rx_en) begin
              state <= L_READY;
            end
          end
          T_WAIT_RFD: begin
            if (bus_i.nrfd && !bus_i.ndac) begin
              cnt   <= '0;
              state <= T_SETTLE;
            end else if ((bus_i.nrfd && bus_i.ndac) || cnt >= CNT_W'(TIMEOUT - 1)) begin
              // Both lines high means nobody is listening at all.
              tx_done <= 1'b1;
              tx_err  <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          T_SETTLE: begin
            if (cnt >= CNT_W'(SETTLE - 1)) begin
              cnt   <= '0;
              state <= T_WAIT_DAC;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          T_WAIT_DAC: begin
            if (bus_i.ndac) begin
              state <= T_RELEASE;
            end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
              tx_done <= 1'b1;
              tx_err  <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          T_RELEASE: begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
          L_READY: begin
            if (!rx_en) begin
              state <= IDLE;
            end else if (!bus_i.dav) begin
              rx_data <= ~bus_i.data;
              rx_eoi  <= ~bus_i.eoi;
              state   <= L_ACCEPT;
            end
          end
          L_ACCEPT: begin
            // No timeout here: the drive may take as long as it likes.
            if (bus_i.dav) begin
              rx_valid <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bus drive, decoded from registered state
  always_comb begin
    bus_o = '1;
    if (talking) begin
      bus_o.data = ~data_latch;
      bus_o.eoi  = ~eoi_latch;
      bus_o.atn  = ~atn_latch;
    end else if (state == IDLE || state == T_RELEASE) begin
      bus_o.atn = ~atn_hold;
    end
    if (state == T_WAIT_DAC)
      bus_o.dav = 1'b0;
    if (state == L_READY)
      bus_o.ndac = 1'b0;
    if (state == L_ACCEPT)
      bus_o.nrfd = 1'b0;
  end

endmodule

// File: tb/tb_ieeedrv_host_hs.sv
// Directed bench for ieeedrv_host_hs: models the drive side of the bus as a
// second wired-AND contributor (dev) and steps the handshake tick by tick.
module tb_ieeedrv_host_hs;
  import ieeedrv_host_hs_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_atn = 1'b0;
  logic       tx_eoi = 1'b0;
  logic       atn_hold = 1'b0;
  logic       tx_done;
  logic       tx_err;
  logic       rx_en = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_eoi;
  st_ieee_bus bus_i;
  st_ieee_bus bus_o;
  st_ieee_bus dev = '1;

  int n_checks = 0;
  int n_errors = 0;
  int ce_div = 0;
  int done_cnt = 0;
  int rxv_cnt = 0;
  int dav_low_cnt = 0;

  assign bus_i = st_ieee_bus'(bus_o & dev);

  ieeedrv_host_hs #(.TIMEOUT(1024), .SETTLE(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx_atn  (tx_atn),
    .tx_eoi  (tx_eoi),
    .atn_hold(atn_hold),
    .tx_done (tx_done),
    .tx_err  (tx_err),
    .rx_en   (rx_en),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_eoi  (rx_eoi),
    .bus_i   (bus_i),
    .bus_o   (bus_o)
  );

  always #5 clk_sys = ~clk_sys;

  // One ce tick every third clock so single-clock pulses are distinguishable.
  always @(negedge clk_sys) begin
    ce_div = (ce_div == 2) ? 0 : ce_div + 1;
    ce = (ce_div == 0);
  end

  always @(posedge clk_sys) begin
    if (tx_done) done_cnt++;
    if (rx_valid) rxv_cnt++;
    if (!bus_o.dav) dav_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after the next clock edge on which ce is high.
  task automatic tick();
    @(posedge clk_sys);
    while (!ce) @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Steps ticks until tx_done is seen; max+1 means it never came.
  task automatic wait_done(input int max, output int n);
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (tx_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic atn, input logic eoi);
    tx_data  = d;
    tx_atn   = atn;
    tx_eoi   = eoi;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    int n;
    int base_done;
    int base_rxv;
    int base_dav;

    // Reset state, sampled while reset is still high
    repeat (5) @(posedge clk_sys);
    #1;
    check("rst_bus", 32'(bus_o), 32'h0000FFFF);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_rxv", 32'(rx_valid), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_rxeoi", 32'(rx_eoi), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(tx_ready), 32'd1);

    // Command 0x28 with listener: RFD after 3 ticks, DAC after 5
    atn_hold = 1'b1;
    dev = '1;
    dev.nrfd = 1'b0;
    dev.ndac = 1'b0;
    send(8'h28, 1'b1, 1'b1);
    check("cmd_ready", 32'(tx_ready), 32'd0);
    check("cmd_atn", 32'(bus_o.atn), 32'd0);
    check("cmd_data", 32'(bus_o.data), 32'hD7);
    check("cmd_eoi_ignored", 32'(bus_o.eoi), 32'd1);
    ticks(3);
    check("cmd_dav_wait_rfd", 32'(bus_o.dav), 32'd1);
    dev.nrfd = 1'b1;
    ticks(3);
    check("cmd_dav_low", 32'(bus_o.dav), 32'd0);
    dev.nrfd = 1'b0;
    ticks(5);
    check("cmd_dav_held", 32'(bus_o.dav), 32'd0);
    dev.ndac = 1'b1;
    tick();
    check("cmd_rel_dav", 32'(bus_o.dav), 32'd1);
    check("cmd_rel_data", 32'(bus_o.data), 32'hFF);
    check("cmd_rel_atn", 32'(bus_o.atn), 32'd0);
    tick();
    check("cmd_done", 32'(tx_done), 32'd1);
    check("cmd_err", 32'(tx_err), 32'd0);
    @(posedge clk_sys);
    #1;
    check("cmd_done_width", 32'(tx_done), 32'd0);
    check("hold_atn_idle", 32'(bus_o.atn), 32'd0);
    atn_hold = 1'b0;
    #1;
    check("idle_atn_rel", 32'(bus_o.atn), 32'd1);

    // Data 0x41 with EOI
    dev = '1;
    dev.ndac = 1'b0;
    send(8'h41, 1'b0, 1'b1);
    check("dat_eoi", 32'(bus_o.eoi), 32'd0);
    check("dat_data", 32'(bus_o.data), 32'hBE);
    check("dat_atn", 32'(bus_o.atn), 32'd1);
    ticks(3);
    check("dat_dav", 32'(bus_o.dav), 32'd0);
    check("dat_eoi_dav", 32'(bus_o.eoi), 32'd0);
    dev.nrfd = 1'b0;
    dev.ndac = 1'b1;
    tick();
    check("dat_rel_dav", 32'(bus_o.dav), 32'd1);
    check("dat_rel_eoi", 32'(bus_o.eoi), 32'd1);
    wait_done(4, n);
    check("dat_done_ticks", 32'(n), 32'd1);
    check("dat_err", 32'(tx_err), 32'd0);

    // No device on the bus
    dev = '1;
    send(8'h12, 1'b0, 1'b0);
    wait_done(10, n);
    check("nodev_ticks", 32'(n), 32'd1);
    check("nodev_err", 32'(tx_err), 32'd1);
    check("nodev_bus", 32'(bus_o), 32'h0000FFFF);

    // Listener holds NRFD low past the timeout
    dev.nrfd = 1'b0;
    dev.ndac = 1'b0;
    base_dav = dav_low_cnt;
    send(8'h77, 1'b0, 1'b0);
    wait_done(1100, n);
    check("tmo_ticks", 32'(n), 32'd1024);
    check("tmo_err", 32'(tx_err), 32'd1);
    check("tmo_no_dav", 32'(dav_low_cnt - base_dav), 32'd0);
    check("tmo_bus", 32'(bus_o), 32'h0000FFFF);

    // Receive ~0x55 with EOI
    dev = '1;
    rx_en = 1'b1;
    base_rxv = rxv_cnt;
    tick();
    check("rx_ndac", 32'(bus_o.ndac), 32'd0);
    check("rx_nrfd_ready", 32'(bus_o.nrfd), 32'd1);
    dev.data = 8'hAA;
    dev.eoi = 1'b0;
    dev.dav = 1'b0;
    tick();
    check("rx_nrfd_low", 32'(bus_o.nrfd), 32'd0);
    check("rx_ndac_rel", 32'(bus_o.ndac), 32'd1);
    check("rx_no_valid_yet", 32'(rx_valid), 32'd0);
    ticks(2);
    check("rx_nrfd_held", 32'(bus_o.nrfd), 32'd0);
    dev = '1;
    rx_en = 1'b0;
    tick();
    check("rx_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'h55);
    check("rx_eoi", 32'(rx_eoi), 32'd1);
    check("rx_nrfd_idle", 32'(bus_o.nrfd), 32'd1);
    ticks(3);
    check("rx_once", 32'(rxv_cnt - base_rxv), 32'd1);

    // tx and rx requested together, then reset in T_WAIT_DAC
    dev = '1;
    dev.ndac = 1'b0;
    rx_en = 1'b1;
    send(8'h3C, 1'b0, 1'b0);
    check("both_tx_wins", 32'(bus_o.data), 32'hC3);
    check("both_not_listen", 32'(bus_o.ndac), 32'd1);
    ticks(3);
    check("both_dav", 32'(bus_o.dav), 32'd0);
    base_done = done_cnt;
    reset = 1'b1;
    rx_en = 1'b0;
    @(posedge clk_sys);
    #1;
    check("rst_mid_bus", 32'(bus_o), 32'h0000FFFF);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    @(negedge clk_sys);
    reset = 1'b0;
    ticks(5);
    check("rst_mid_no_done", 32'(done_cnt - base_done), 32'd0);
    check("rst_mid_bus_after", 32'(bus_o), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
